// File: rtl/eth_sw_pkg.sv
// Shared defaults and the egress framing FSM state type for the switch egress path.
package eth_sw_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IN_PKT = 2'd1,
      ST_DROP   = 2'd2
   } egress_state_e;

endpackage

// File: rtl/eth_skid_buf.sv
// Two-entry valid/ready buffer between the switch read side and the MAC.
module eth_skid_buf #(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push;
   logic             pop;

   assign out_valid = (count_q != 2'd0);
   assign in_ready  = (count_q != 2'd2) || out_ready;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // Head word is masked while empty so the MAC side reads zero after reset.
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count_o   = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: rtl/eth_egress_ctrl.sv
// Egress controller: pops the switch output FIFO, checks packet framing and
// forwards well-formed words to the MAC through a two-entry buffer.
module eth_egress_ctrl
   import eth_sw_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int MAX_PKT_WORDS = 16,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] sw_data,
   input  logic                  sw_sop,
   input  logic                  sw_eop,
   input  logic                  sw_empty,
   output logic                  sw_rd_en,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_sop,
   output logic                  tx_eop,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  busy
);

   localparam int WCNT_W = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(MAX_PKT_WORDS - 1);

   egress_state_e         state_q, state_d;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [CNT_WIDTH-1:0]  pkt_cnt_q, err_cnt_q;
   logic                  vld_p1_q;
   logic                  fwd, fwd_eop, pkt_inc, err_inc;
   logic                  buf_in_ready, tx_pop;
   logic [1:0]            buf_count;
   logic [2:0]            occ_after;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic en);
      return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
   endfunction

   // Occupancy once this cycle's MAC transfer leaves, plus the word already on the bus.
   assign tx_pop    = tx_valid && tx_ready;
   assign occ_after = {1'b0, buf_count} - {2'b0, tx_pop} + {2'b0, vld_p1_q};
   assign sw_rd_en  = !rst && !sw_empty && buf_in_ready && (occ_after < 3'd2);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      fwd     = 1'b0;
      fwd_eop = sw_eop;
      pkt_inc = 1'b0;
      err_inc = 1'b0;
      if (vld_p1_q) begin
         case (state_q)
            ST_IN_PKT: begin
               fwd = 1'b1;
               if (sw_sop) begin
                  err_inc = 1'b1;
                  wcnt_d  = WCNT_W'(1);
                  state_d = sw_eop ? ST_IDLE : ST_IN_PKT;
               end else if (sw_eop) begin
                  pkt_inc = 1'b1;
                  state_d = ST_IDLE;
               end else if (wcnt_q == LAST_IDX) begin
                  fwd_eop = 1'b1;
                  err_inc = 1'b1;
                  state_d = ST_DROP;
               end else begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
            end
            default: begin
               if (sw_sop) begin
                  fwd    = 1'b1;
                  wcnt_d = WCNT_W'(1);
                  if (sw_eop) begin
                     pkt_inc = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_IN_PKT;
                  end
               end else if (state_q == ST_IDLE) begin
                  err_inc = 1'b1;
                  state_d = ST_DROP;
               end else if (sw_eop) begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wcnt_q    <= '0;
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
         vld_p1_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         pkt_cnt_q <= sat_inc(pkt_cnt_q, pkt_inc);
         err_cnt_q <= sat_inc(err_cnt_q, err_inc);
         vld_p1_q  <= sw_rd_en;
      end
   end

   eth_skid_buf #(
      .WIDTH (DATA_WIDTH + 2)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (fwd),
      .in_ready  (buf_in_ready),
      .in_data   ({sw_sop, fwd_eop, sw_data}),
      .out_valid (tx_valid),
      .out_ready (tx_ready),
      .out_data  ({tx_sop, tx_eop, tx_data}),
      .count_o   (buf_count)
   );

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
   assign busy    = (state_q != ST_IDLE) || (buf_count != 2'd0);

endmodule

// File: tb/tb_eth_egress_ctrl.sv
// Directed bench for eth_egress_ctrl with a behavioural latency-1 switch FIFO.
module tb_eth_egress_ctrl;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] sw_data = '0;
   logic          sw_sop = 1'b0;
   logic          sw_eop = 1'b0;
   logic          sw_empty = 1'b1;
   logic          sw_rd_en;
   logic [DW-1:0] tx_data;
   logic          tx_sop, tx_eop, tx_valid;
   logic          tx_ready = 1'b0;
   logic [CW-1:0] pkt_cnt, err_cnt;
   logic          busy;

   always #5 clk = ~clk;

   eth_egress_ctrl #(
      .DATA_WIDTH    (DW),
      .MAX_PKT_WORDS (16),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sw_data  (sw_data),
      .sw_sop   (sw_sop),
      .sw_eop   (sw_eop),
      .sw_empty (sw_empty),
      .sw_rd_en (sw_rd_en),
      .tx_data  (tx_data),
      .tx_sop   (tx_sop),
      .tx_eop   (tx_eop),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt),
      .busy     (busy)
   );

   typedef logic [DW+1:0] word_t;   // {sop, eop, data}

   word_t src_q[$];
   word_t exp_q[$];
   word_t got_q[$];
   int    got_cyc[$];
   int    n_assert = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    popped = 0;
   int    ready_mode = 0;   // 0: always ready, 1: toggling, 2: never ready
   bit    chk_occ = 1'b0;
   bit    stall_prev = 1'b0;
   word_t stall_word = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_mode(input int m);
      ready_mode = m;
      tx_ready   = (m != 2);
   endtask

   task automatic tick();
      logic  rd;
      word_t cur;
      @(negedge clk);
      rd  = sw_rd_en;
      cur = {tx_sop, tx_eop, tx_data};
      if (stall_prev) begin
         check("stall_valid", 64'(tx_valid), 64'(1));
         check("stall_word", 64'(cur), 64'(stall_word));
      end
      if (chk_occ) check("occupancy_le2", 64'(popped - got_q.size() <= 2), 64'(1));
      stall_prev = tx_valid && !tx_ready;
      stall_word = cur;
      if (tx_valid && tx_ready) begin
         got_q.push_back(cur);
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rd && src_q.size() > 0) begin
         cur = src_q.pop_front();
         {sw_sop, sw_eop, sw_data} = cur;
         popped++;
      end else begin
         // Decoy word: any sample taken off the read-latency slot would forward it.
         sw_sop  = 1'b1;
         sw_eop  = 1'b1;
         sw_data = 32'hDEAD_0000 | 32'(cyc);
      end
      sw_empty = (src_q.size() == 0);
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = !tx_ready;
         default: tx_ready = 1'b0;
      endcase
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      src_q.delete();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
      sw_empty   = 1'b1;
      sw_sop     = 1'b0;
      sw_eop     = 1'b0;
      sw_data    = '0;
      tx_ready   = 1'b0;
      stall_prev = 1'b0;
      chk_occ    = 1'b0;
      popped     = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic add_pkt(input int n, input logic [DW-1:0] base, input bit fwd);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w = {(i == 0), (i == n - 1), base + DW'(i)};
         src_q.push_back(w);
         if (fwd) exp_q.push_back(w);
      end
      sw_empty = (src_q.size() == 0);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
      end
   endtask

   initial begin
      word_t w;

      // Reset values while the switch claims data is available
      sw_empty = 1'b0;
      #3;
      check("rst_rd_en", 64'(sw_rd_en), 64'(0));
      check("rst_tx_valid", 64'(tx_valid), 64'(0));
      check("rst_tx_sop", 64'(tx_sop), 64'(0));
      check("rst_tx_eop", 64'(tx_eop), 64'(0));
      check("rst_tx_data", 64'(tx_data), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
      check("rst_err_cnt", 64'(err_cnt), 64'(0));

      // Three 4-word packets at full rate
      reset_dut();
      set_mode(0);
      add_pkt(4, 32'h1000_0000, 1'b1);
      add_pkt(4, 32'h2000_0000, 1'b1);
      add_pkt(4, 32'h3000_0000, 1'b1);
      repeat (24) tick();
      compare_stream("t1");
      if (got_cyc.size() == 12) check("t1_back_to_back", 64'(got_cyc[11] - got_cyc[0]), 64'(11));
      else check("t1_back_to_back_count", 64'(got_cyc.size()), 64'(12));
      check("t1_pkt_cnt", 64'(pkt_cnt), 64'(3));
      check("t1_err_cnt", 64'(err_cnt), 64'(0));
      check("t1_busy_idle", 64'(busy), 64'(0));

      // Same stream with tx_ready toggling every cycle
      reset_dut();
      set_mode(1);
      chk_occ = 1'b1;
      add_pkt(4, 32'h1000_0000, 1'b1);
      add_pkt(4, 32'h2000_0000, 1'b1);
      add_pkt(4, 32'h3000_0000, 1'b1);
      repeat (40) tick();
      compare_stream("t2");
      check("t2_pkt_cnt", 64'(pkt_cnt), 64'(3));
      check("t2_err_cnt", 64'(err_cnt), 64'(0));

      // Single-word packet
      reset_dut();
      set_mode(0);
      add_pkt(1, 32'h0000_ABCD, 1'b1);
      repeat (6) tick();
      compare_stream("t3");
      check("t3_pkt_cnt", 64'(pkt_cnt), 64'(1));
      check("t3_err_cnt", 64'(err_cnt), 64'(0));

      // Two orphan words followed by a 2-word packet
      reset_dut();
      set_mode(0);
      src_q.push_back({1'b0, 1'b0, 32'h0BAD_0001});
      src_q.push_back({1'b0, 1'b0, 32'h0BAD_0002});
      src_q.push_back({1'b1, 1'b0, 32'h0000_EFEF});
      src_q.push_back({1'b0, 1'b1, 32'h0000_1234});
      exp_q.push_back({1'b1, 1'b0, 32'h0000_EFEF});
      exp_q.push_back({1'b0, 1'b1, 32'h0000_1234});
      sw_empty = 1'b0;
      repeat (10) tick();
      compare_stream("t4");
      check("t4_pkt_cnt", 64'(pkt_cnt), 64'(1));
      check("t4_err_cnt", 64'(err_cnt), 64'(1));

      // 20-word packet truncated at 16 words
      reset_dut();
      set_mode(0);
      add_pkt(20, 32'h4000_0000, 1'b0);
      for (int i = 0; i < 16; i++) begin
         w = {(i == 0), (i == 15), 32'h4000_0000 + 32'(i)};
         exp_q.push_back(w);
      end
      repeat (30) tick();
      compare_stream("t5");
      check("t5_pkt_cnt", 64'(pkt_cnt), 64'(0));
      check("t5_err_cnt", 64'(err_cnt), 64'(1));
      check("t5_state_idle", 64'(busy), 64'(0));

      // Reset mid-packet with the MAC stalled
      reset_dut();
      set_mode(2);
      add_pkt(4, 32'h6000_0000, 1'b0);
      repeat (5) tick();
      check("t6_words_read", 64'(popped), 64'(2));
      check("t6_pre_valid", 64'(tx_valid), 64'(1));
      check("t6_pre_busy", 64'(busy), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("t6_rst_valid", 64'(tx_valid), 64'(0));
      check("t6_rst_data", 64'(tx_data), 64'(0));
      check("t6_rst_sop", 64'(tx_sop), 64'(0));
      check("t6_rst_rd_en", 64'(sw_rd_en), 64'(0));
      check("t6_rst_busy", 64'(busy), 64'(0));
      reset_dut();
      set_mode(0);
      add_pkt(2, 32'h5500_0000, 1'b1);
      repeat (8) tick();
      compare_stream("t6");
      check("t6_pkt_cnt", 64'(pkt_cnt), 64'(1));
      check("t6_err_cnt", 64'(err_cnt), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_egress_ctrl.md
ETH_EGRESS_CTRL -- requirements
Module: eth_egress_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of switch and TX data words.
REQ-002 Parameter MAX_PKT_WORDS, default 16, longest legal packet in words.
REQ-003 Parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sw_data  in  DATA_WIDTH  switch output-port data word (outdataA/outdataB).
REQ-007 sw_sop  in  1  start-of-packet qualifier of sw_data.
REQ-008 sw_eop  in  1  end-of-packet qualifier of sw_data.
REQ-009 sw_empty  in  1  switch output FIFO empty (portXstall_empty).
REQ-010 sw_rd_en  out  1  pop request to switch output FIFO (one rd_en[] bit).
REQ-011 tx_data  out  DATA_WIDTH  data toward MAC.
REQ-012 tx_sop, tx_eop  out  1 each  framing toward MAC.
REQ-013 tx_valid  out  1  tx_* word valid; tx_ready  in  1  MAC accepts.
REQ-014 pkt_cnt, err_cnt  out  CNT_WIDTH each  good-packet and framing-error counts.
REQ-015 busy  out  1  high while state is not IDLE or buffer non-empty.

Function
REQ-016 sw_rd_en SHALL assert only when sw_empty=0 and buffer occupancy plus reads in flight < 2.
REQ-017 sw_data/sw_sop/sw_eop SHALL be sampled exactly one cycle after sw_rd_en is high (fixed read latency 1).
REQ-018 Sampled words SHALL enter a 2-entry buffer; transfer to MAC occurs on cycles with tx_valid=1 and tx_ready=1.
REQ-019 tx_* SHALL hold stable while tx_valid=1 and tx_ready=0; no word lost or duplicated under any tx_ready pattern.
REQ-020 Sustained throughput SHALL be one word per cycle when sw_empty=0 and tx_ready=1.
REQ-021 FSM states: IDLE, IN_PKT, DROP.
REQ-022 IDLE + word with sop=1, eop=0: forward, word count=1, go IN_PKT.
REQ-023 IDLE + word with sop=1, eop=1: forward, pkt_cnt+1, stay IDLE.
REQ-024 IDLE + word with sop=0: discard, err_cnt+1, go DROP.
REQ-025 IN_PKT + eop=1 (sop=0): forward, pkt_cnt+1, go IDLE.
REQ-026 IN_PKT + sop=1: forward as new packet start (tx_sop=1), err_cnt+1, word count=1, stay IN_PKT (sop=eop=1 goes IDLE, no pkt_cnt increment).
REQ-027 IN_PKT word reaching MAX_PKT_WORDS without eop: forward with tx_eop forced 1, err_cnt+1, go DROP.
REQ-028 DROP: discard words until one with sop=1, then handle as in IDLE; word with eop=1 and sop=0 discarded, go IDLE.
REQ-029 Discarded words SHALL not enter the buffer.
REQ-030 pkt_cnt and err_cnt SHALL saturate at all-ones, never wrap.
REQ-031 Counters increment when the classifying word is sampled, independent of tx_ready.

Reset
REQ-032 rst=1 SHALL immediately force sw_rd_en=0, tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0, busy=0, pkt_cnt=0, err_cnt=0, state IDLE, buffer empty.
REQ-033 Reset mid-packet or with reads in flight SHALL discard all in-flight and buffered words; the first sampled word after release is classified from IDLE.

Structure
REQ-034 Package eth_sw_pkg SHALL hold DATA_WIDTH default, CNT_WIDTH default, and the egress FSM state enum.
REQ-035 Buffer SHALL be sub-module eth_skid_buf (2-entry, valid/ready both sides, async active-high reset).

Verification
REQ-036 Three 4-word packets, sw_empty=0, tx_ready=1 -> 12 words out in back-to-back cycles, tx_sop on words 1/5/9, tx_eop on 4/8/12, pkt_cnt=3, err_cnt=0.
REQ-037 Same stream, tx_ready toggling 1,0 every cycle -> identical word sequence, tx_data stable across every stalled cycle, sw_rd_en never overfills buffer.
REQ-038 Single word sop=1,eop=1 data 32'hABCD -> one tx word with tx_sop=tx_eop=1, pkt_cnt=1.
REQ-039 Two orphan words (sop=0) then a 2-word packet 32'hEFEF,32'h1234 -> only packet forwarded, err_cnt=1, pkt_cnt=1.
REQ-040 20-word packet, MAX_PKT_WORDS=16 -> 16 words out, tx_eop on word 16, words 17-20 dropped, err_cnt=1, pkt_cnt=0.
REQ-041 rst pulsed after word 2 of a 4-word packet with tx_ready=0 -> outputs zero at once; next 2-word sop..eop packet forwarded cleanly, pkt_cnt=1.
